matrix_drain_serializer: RTL and testbench

Output-side counterpart of the matrix MAC stage. The MAC produces its result as one wide flat matrix bus. This block captures that bus on a load handshake and streams it out row-major, LANES elements per beat, over a valid/ready interface to downstream storage or the next op. It buffers a single matrix and owns all beat, row and last-flag sequencing.

---
 rtl/mac_stream_pkg.sv | 23 ++
 rtl/matrix_beat_mux.sv | 28 ++
 rtl/matrix_drain_serializer.sv | 141 ++++++++++++++
 tb/tb_matrix_drain_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stream_pkg.sv
// Shared definitions for the matrix MAC streaming blocks: index-width
// helper, stream FSM states and the flat-matrix element offset.
package mac_stream_pkg;

  // Stream-side FSM: waiting for a matrix, or draining one.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Counter width for n values, never narrower than one bit so that
  // degenerate sizes (n == 1) still produce a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit offset of element (r, c) in a row-major flat matrix bus.
  function automatic int element_offset(input int r, input int c,
                                        input int cols, input int dw);
    return (r * cols + c) * dw;
  endfunction

endpackage

// File: rtl/matrix_beat_mux.sv
// Combinational lane selector: extracts the LANES elements of
// (row, beat) from the flat matrix buffer so the FSM never touches
// wide indexing directly.
module matrix_beat_mux
  import mac_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 8,
  parameter int LANES      = 4,
  parameter int ROW_W      = 2,
  parameter int BEAT_W     = 1
) (
  input  logic [DATA_WIDTH*ROWS*COLS-1:0] matrix,
  input  logic [ROW_W-1:0]                row,
  input  logic [BEAT_W-1:0]               beat,
  output logic [DATA_WIDTH*LANES-1:0]     slice
);

  // Lane g carries column beat*LANES+g of the selected row. A right
  // shift by the element offset keeps the select index width-agnostic.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign slice[g*DATA_WIDTH +: DATA_WIDTH] =
      DATA_WIDTH'(matrix >> element_offset(int'(row), int'(beat) * LANES + g,
                                           COLS, DATA_WIDTH));
  end

endmodule

// File: rtl/matrix_drain_serializer.sv
// Captures one flat MAC result matrix on a load handshake and streams it
// out row-major, LANES elements per beat, over valid/ready.
//
// Handshake rules (both interfaces): a transfer happens on a rising edge
// where valid && ready are both high. Once out_valid is raised it stays
// high, with out_data/out_row/out_eol/out_last frozen, until out_ready
// completes the transfer. load_ready is high only while IDLE; load_valid
// seen during STREAM is ignored.
module matrix_drain_serializer
  import mac_stream_pkg::*;
#(
  parameter int  DATA_WIDTH    = 8,
  parameter int  ROWS          = 4,
  parameter int  COLS          = 8,
  parameter int  LANES         = 4,
  localparam int BEATS_PER_ROW = COLS / LANES,
  localparam int ROW_W         = idx_width(ROWS),
  localparam int BEAT_W        = idx_width(BEATS_PER_ROW)
) (
  input  logic                           clk_p,
  input  logic                           rst_p,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [DATA_WIDTH*ROWS*COLS-1:0] load_matrix,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*LANES-1:0]    out_data,
  output logic [ROW_W-1:0]               out_row,
  output logic                           out_eol,
  output logic                           out_last,
  output logic                           busy
);

  if ((COLS % LANES) != 0) begin : g_bad_cols
    $error("matrix_drain_serializer: COLS must be a multiple of LANES");
  end

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  stream_state_e                    state, state_next;
  logic [DATA_WIDTH*ROWS*COLS-1:0]  buffer;
  logic [BEAT_W-1:0]                beat, beat_next;
  logic [ROW_W-1:0]                 row, row_next;
  logic [DATA_WIDTH*LANES-1:0]      slice;
  logic                             load_fire;
  logic                             out_fire;
  logic                             final_fire;

  assign load_fire  = load_valid && (state == IDLE);
  assign out_fire   = out_valid && out_ready;
  assign final_fire = out_fire && out_last;

  assign load_ready = (state == IDLE);
  assign busy       = (state == STREAM);
  assign out_row    = row;

  // State register.
  always_ff @(posedge clk_p) begin
    if (rst_p) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a load starts the stream, the final handshake ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_fire)  state_next = STREAM;
      STREAM:  if (final_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position of the beat to present next: advances only on a
  // non-final handshake, wrapping beat into row at end of line.
  always_comb begin
    beat_next = beat;
    row_next  = row;
    if (out_fire && !out_last) begin
      if (beat == LAST_BEAT) begin
        beat_next = '0;
        row_next  = row + ROW_W'(1);
      end else begin
        beat_next = beat + BEAT_W'(1);
      end
    end
  end

  matrix_beat_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LANES      (LANES),
    .ROW_W      (ROW_W),
    .BEAT_W     (BEAT_W)
  ) u_beat_mux (
    .matrix (buffer),
    .row    (row_next),
    .beat   (beat_next),
    .slice  (slice)
  );

  // Matrix buffer: contents are only meaningful after a load, so no reset.
  always_ff @(posedge clk_p) begin
    if (load_fire && !rst_p) buffer <= load_matrix;
  end

  // Output beat register: primes beat (0,0) the cycle after a load, then
  // refills whenever the current beat is taken or not yet valid.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      beat      <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_fire) begin
      beat      <= '0;
      row       <= '0;
      out_valid <= 1'b0;
    end else if (state == STREAM) begin
      if (final_fire) begin
        beat      <= '0;
        row       <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_eol   <= 1'b0;
        out_last  <= 1'b0;
      end else if (!out_valid || out_ready) begin
        beat      <= beat_next;
        row       <= row_next;
        out_valid <= 1'b1;
        out_data  <= slice;
        out_eol   <= (beat_next == LAST_BEAT);
        out_last  <= (beat_next == LAST_BEAT) && (row_next == LAST_ROW);
      end
    end
  end

endmodule

// File: tb/tb_matrix_drain_serializer.sv
// Directed bench for matrix_drain_serializer with ROWS=2, COLS=4, LANES=2.
module tb_matrix_drain_serializer;

  localparam int DW    = 8;
  localparam int ROWS  = 2;
  localparam int COLS  = 4;
  localparam int LANES = 2;
  localparam int BPR   = COLS / LANES;
  localparam int MW    = DW * ROWS * COLS;
  localparam int OW    = DW * LANES;
  localparam int EW    = 1 + 1 + 1 + OW;   // {row, eol, last, data}

  logic          clk_p = 1'b0;
  logic          rst_p;
  logic          load_valid;
  logic          load_ready;
  logic [MW-1:0] load_matrix;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [0:0]    out_row;
  logic          out_eol;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int last_count = 0;

  logic [EW-1:0] exp_q[$];

  matrix_drain_serializer #(
    .DATA_WIDTH (DW),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LANES      (LANES)
  ) dut (
    .clk_p       (clk_p),
    .rst_p       (rst_p),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_matrix (load_matrix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_eol     (out_eol),
    .out_last    (out_last),
    .busy        (busy)
  );

  // Clock
  always #5 clk_p = ~clk_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  function automatic logic [MW-1:0] seq_matrix(input int base);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[(r*COLS+c)*DW +: DW] = 8'(base + r*COLS + c);
    return m;
  endfunction

  function automatic logic [MW-1:0] alt_matrix();
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < ROWS*COLS; k++)
      m[k*DW +: DW] = (k % 2 == 0) ? 8'h80 : 8'h7F;
    return m;
  endfunction

  // Expected beats in row-major order from the element layout.
  task automatic push_expected(input logic [MW-1:0] m);
    logic [OW-1:0] d;
    logic          eol, last;
    for (int r = 0; r < ROWS; r++) begin
      for (int b = 0; b < BPR; b++) begin
        for (int i = 0; i < LANES; i++)
          d[i*DW +: DW] = m[(r*COLS + b*LANES + i)*DW +: DW];
        eol  = (b == BPR - 1);
        last = eol && (r == ROWS - 1);
        exp_q.push_back({1'(r), eol, last, d});
      end
    end
  endtask

  // Offer a matrix; returns #1 after the accepting edge.
  task automatic do_load(input logic [MW-1:0] m);
    int n;
    load_matrix = m;
    load_valid  = 1'b1;
    n = 0;
    while (!load_ready && n < 50) begin
      tick();
      n++;
    end
    chk("load_wait_bound", 32'(n < 50), 32'd1);
    push_expected(m);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 100), 32'd1);
  endtask

  // Scoreboard monitor: sampled mid-cycle, pops one expectation per handshake
  // and checks that a stalled beat stays frozen.
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_beat;
  always @(negedge clk_p) begin
    logic [EW-1:0] obs;
    obs = {out_row, out_eol, out_last, out_data};
    if (!rst_p && prev_stall && out_valid)
      chk("stall_hold", 32'(obs), 32'(prev_beat));
    if (!rst_p && out_valid && out_ready) begin
      hs_count++;
      if (out_last) last_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(obs), 32'h0);
      end else begin
        chk("beat", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = !rst_p && out_valid && !out_ready;
    prev_beat  = obs;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] m1;
    int hs0, last0, n;
    m1 = seq_matrix(1);
    rst_p = 1'b1; load_valid = 1'b0; load_matrix = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst_p = 1'b0;

    // Reset state
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_out_row",    32'(out_row),    32'd0);
    chk("rst_out_eol",    32'(out_eol),    32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_busy",       32'(busy),       32'd0);

    // 1: full throughput, latency and exact beat contents
    hs0 = hs_count; last0 = last_count;
    do_load(m1);
    chk("t1_valid_n",      32'(out_valid),  32'd0);
    chk("t1_ready_n",      32'(load_ready), 32'd0);
    chk("t1_busy_n",       32'(busy),       32'd1);
    tick();
    chk("t1_valid_n1",     32'(out_valid),  32'd1);
    chk("t1_b0_data",      32'(out_data),   32'h0201);
    chk("t1_b0_row",       32'(out_row),    32'd0);
    chk("t1_b0_eol",       32'(out_eol),    32'd0);
    tick();
    chk("t1_b1_data",      32'(out_data),   32'h0403);
    chk("t1_b1_eol",       32'(out_eol),    32'd1);
    chk("t1_b1_last",      32'(out_last),   32'd0);
    tick();
    chk("t1_b2_data",      32'(out_data),   32'h0605);
    chk("t1_b2_row",       32'(out_row),    32'd1);
    tick();
    chk("t1_b3_data",      32'(out_data),   32'h0807);
    chk("t1_b3_last",      32'(out_last),   32'd1);
    chk("t1_b3_eol",       32'(out_eol),    32'd1);
    tick();
    chk("t1_end_valid",    32'(out_valid),  32'd0);
    chk("t1_end_ready",    32'(load_ready), 32'd1);
    chk("t1_end_busy",     32'(busy),       32'd0);
    chk("t1_end_data",     32'(out_data),   32'd0);
    chk("t1_hs",           32'(hs_count - hs0),     32'd4);
    chk("t1_last_cnt",     32'(last_count - last0), 32'd1);

    // 2: three-cycle stall on beat 1
    hs0 = hs_count;
    do_load(m1);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_data", 32'(out_data), 32'h0403);
      chk("t2_stall_eol",  32'(out_eol),  32'd1);
      tick();
    end
    drain();
    chk("t2_hs", 32'(hs_count - hs0), 32'd4);

    // 3: load offered mid-stream is ignored
    do_load(m1);
    load_matrix = {(MW/8){8'h55}};
    load_valid  = 1'b1;
    tick();
    chk("t3_ready_low_a", 32'(load_ready), 32'd0);
    tick();
    chk("t3_ready_low_b", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    drain();
    chk("t3_ready_after", 32'(load_ready), 32'd1);

    // 4: reset mid-stream discards the partial matrix
    hs0 = hs_count; last0 = last_count;
    do_load(m1);
    tick();
    tick();
    tick();
    rst_p = 1'b1; out_ready = 1'b0;
    tick();
    rst_p = 1'b0;
    exp_q.delete();
    chk("t4_valid",   32'(out_valid),  32'd0);
    chk("t4_busy",    32'(busy),       32'd0);
    chk("t4_ready",   32'(load_ready), 32'd1);
    chk("t4_hs",      32'(hs_count - hs0),     32'd2);
    chk("t4_no_last", 32'(last_count - last0), 32'd0);
    out_ready = 1'b1;
    do_load(m1);
    tick();
    chk("t4_restart_data", 32'(out_data), 32'h0201);
    chk("t4_restart_row",  32'(out_row),  32'd0);
    drain();

    // 5: signed extremes pass bit-exact
    do_load(alt_matrix());
    tick();
    chk("t5_b0_data", 32'(out_data), 32'h7F80);
    drain();

    // 6: back-to-back loads with load_valid held high
    hs0 = hs_count;
    load_matrix = m1;
    load_valid  = 1'b1;
    chk("t6_ready0", 32'(load_ready), 32'd1);
    push_expected(m1);
    tick();
    load_matrix = seq_matrix(8'h11);
    n = 0;
    while (!load_ready && n < 20) begin
      tick();
      n++;
    end
    chk("t6_gap",        32'(n),         32'd5);
    chk("t6_idle_busy",  32'(busy),      32'd0);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    push_expected(seq_matrix(8'h11));
    tick();
    chk("t6_accept2",    32'(load_ready), 32'd0);
    chk("t6_busy2",      32'(busy),       32'd1);
    load_valid = 1'b0;
    drain();
    chk("t6_hs", 32'(hs_count - hs0), 32'd8);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
